xge_mac_regb_initiator: RTL

// - Initiator (master) end of the register-block bus: turns one-at-a-time commands into regb_* accesses.
// - Waits for ack/error from the target and returns rdata/status on a valid/ready response channel.
// - Sits between the management/OCP-side command source and the xge_mac register-block target.
// - Adds a timeout so a missing target cannot hang the command source.

---
 rtl/xge_mac_regb_initiator.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/xge_mac_regb_initiator.sv
// ---------------------------------------------------------------------------
// xge_mac_regb_initiator
//
// Initiator (master) end of the xge_mac register-block bus. Accepts one
// command at a time on a valid/ready command channel, issues a single-cycle
// regb_wen_o / regb_ren_o strobe, waits for regb_ack_i (bounded by a
// timeout), and returns read data and status on a valid/ready response
// channel. At most one command is in flight.
//
// Optional feature macro: XGE_REGB_INIT_RETRY_EN
//   When defined, a target error (not a timeout) is retried up to RETRY_MAX
//   times before being reported; rsp_retry_cnt_o reports the retries used.
//   When undefined, every target error is reported immediately and
//   rsp_retry_cnt_o is always 0.
//
// Ports
//   clk, resetn        clock, asynchronous active-low reset
//   cmd_valid_i/ready  command handshake
//   cmd_write_i        1 = write, 0 = read
//   cmd_addr_i         register address
//   cmd_wdata_i        write data
//   rsp_valid_o/ready  response handshake (response held until ready)
//   rsp_rdata_o        read data; 0 for writes, errors and timeouts
//   rsp_error_o        target error or timeout
//   rsp_timeout_o      no ack within TIMEOUT_CYCLES WAIT cycles
//   rsp_retry_cnt_o    retries used
//   regb_addr_o        bus address (held from REQ through WAIT)
//   regb_wbdata_o      bus write data
//   regb_wen_o         bus write strobe (one cycle)
//   regb_ren_o         bus read strobe (one cycle)
//   regb_rdata_i       bus read data, valid in the ack cycle
//   regb_ack_i         bus ack
//   regb_error_i       bus error, qualified by regb_ack_i
// ---------------------------------------------------------------------------
module xge_mac_regb_initiator #(
  parameter int unsigned REG_ADDR_WIDTH = 32,
  parameter int unsigned REG_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned RETRY_MAX      = 2
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic                      cmd_write_i,
  input  logic [REG_ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [REG_DATA_WIDTH-1:0] cmd_wdata_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [REG_DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                      rsp_error_o,
  output logic                      rsp_timeout_o,
  output logic [1:0]                rsp_retry_cnt_o,
  output logic [REG_ADDR_WIDTH-1:0] regb_addr_o,
  output logic [REG_DATA_WIDTH-1:0] regb_wbdata_o,
  output logic                      regb_wen_o,
  output logic                      regb_ren_o,
  input  logic [REG_DATA_WIDTH-1:0] regb_rdata_i,
  input  logic                      regb_ack_i,
  input  logic                      regb_error_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  // Counter only needs to reach TIMEOUT_CYCLES-1: the last WAIT cycle is
  // recognised by the count value rather than by counting past it.
  localparam int unsigned TCNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

`ifdef XGE_REGB_INIT_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  // The retry counter is 2 bits wide, so the limit saturates at 3. With the
  // feature off the limit is 0, which makes the retry branch unreachable.
  localparam int unsigned RETRY_LIMIT = RETRY_EN ? ((RETRY_MAX > 3) ? 3 : RETRY_MAX) : 0;
  localparam logic [1:0]  RETRY_LIM   = 2'(RETRY_LIMIT);

  state_t                    state;
  logic                      write_q;
  logic [REG_ADDR_WIDTH-1:0] addr_q;
  logic [REG_DATA_WIDTH-1:0] wdata_q;
  logic [TCNT_W-1:0]         tcnt_q;
  logic [1:0]                retry_q;
  logic [REG_DATA_WIDTH-1:0] rdata_q;
  logic                      error_q;
  logic                      timeout_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      tcnt_q    <= '0;
      retry_q   <= '0;
      rdata_q   <= '0;
      error_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (cmd_valid_i) begin
            write_q   <= cmd_write_i;
            addr_q    <= cmd_addr_i;
            wdata_q   <= cmd_wdata_i;
            tcnt_q    <= '0;
            retry_q   <= '0;
            rdata_q   <= '0;
            error_q   <= 1'b0;
            timeout_q <= 1'b0;
            state     <= S_REQ;
          end
        end

        S_REQ: begin
          state <= S_WAIT;
        end

        S_WAIT: begin
          // Ack is tested first so an ack in the final WAIT cycle wins
          // over the timeout.
          if (regb_ack_i) begin
            if (regb_error_i && (retry_q != RETRY_LIM)) begin
              retry_q <= retry_q + 2'd1;
              tcnt_q  <= '0;
              state   <= S_REQ;
            end else begin
              rdata_q <= (regb_error_i || write_q) ? '0 : regb_rdata_i;
              error_q <= regb_error_i;
              state   <= S_RESP;
            end
          end else if (tcnt_q == TCNT_LAST) begin
            timeout_q <= 1'b1;
            error_q   <= 1'b1;
            rdata_q   <= '0;
            state     <= S_RESP;
          end else begin
            tcnt_q <= tcnt_q + TCNT_W'(1);
          end
        end

        S_RESP: begin
          if (rsp_ready_i) begin
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  // Handshake and strobe outputs are pure state decodes, so the asynchronous
  // reset of the state register drops them immediately.
  assign cmd_ready_o     = (state == S_IDLE);
  assign rsp_valid_o     = (state == S_RESP);
  assign regb_wen_o      = (state == S_REQ) &&  write_q;
  assign regb_ren_o      = (state == S_REQ) && !write_q;
  assign regb_addr_o     = addr_q;
  assign regb_wbdata_o   = wdata_q;
  assign rsp_rdata_o     = rdata_q;
  assign rsp_error_o     = error_q;
  assign rsp_timeout_o   = timeout_q;
  assign rsp_retry_cnt_o = retry_q;

endmodule
